// File: rtl/ps2_scan_controller.sv
// PS/2 scan-code sequencer: synchronises the receiver's byte strobe, acknowledges
// each byte, folds E0/F0 prefix sequences into single key events and queues them
// for a valid/ready consumer.
module ps2_scan_controller #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       scan_ready,
  input  logic [7:0]                 scan_code,
  output logic                       read,
  output logic [7:0]                 evt_code,
  output logic                       evt_ext,
  output logic                       evt_release,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(DEPTH+1)-1:0] evt_count,
  output logic                       overflow,
  output logic                       proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_E0   = 2'd1;
  localparam logic [1:0] S_F0   = 2'd2;
  localparam logic [1:0] S_E0F0 = 2'd3;

  // Synchroniser and handshake state
  logic          r_sync_q1;
  logic          r_sync_q2;
  logic          r_read;
  logic          w_byte_stb;

  // Prefix decoder state
  logic [1:0]    r_state;
  logic [TW-1:0] r_to_cnt;
  logic          r_push;
  logic [9:0]    r_push_data;   // {ext, release, code}
  logic          r_proto_err;

  // Event FIFO
  logic [9:0]    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr_en;
  logic [9:0]    w_head;
  logic          w_bad_byte;

  assign w_byte_stb = r_sync_q1 & ~r_sync_q2;
  assign w_bad_byte = (scan_code == 8'h00) || (scan_code == 8'hFF);

  // Two-flop synchroniser for scan_ready and the registered acknowledge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_q1 <= 1'b0;
      r_sync_q2 <= 1'b0;
      r_read    <= 1'b0;
    end else begin
      r_sync_q1 <= scan_ready;
      r_sync_q2 <= r_sync_q1;
      r_read    <= w_byte_stb;
    end
  end

  // Prefix decoder with inactivity timeout; a byte arriving in the timeout cycle wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_to_cnt    <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_proto_err <= 1'b0;
      if (w_byte_stb) begin
        r_to_cnt <= '0;
        if (scan_code == 8'hE1) begin
          // Pause prefix: abandon any partial sequence silently
          r_state <= S_IDLE;
        end else if (w_bad_byte) begin
          r_proto_err <= 1'b1;
          r_state     <= S_IDLE;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (scan_code == 8'hE0) begin
                r_state <= S_E0;
              end else if (scan_code == 8'hF0) begin
                r_state <= S_F0;
              end else begin
                r_push      <= 1'b1;
                r_push_data <= {2'b00, scan_code};
              end
            end
            S_E0: begin
              if (scan_code == 8'hF0) begin
                r_state <= S_E0F0;
              end else if (scan_code != 8'hE0) begin
                r_push      <= 1'b1;
                r_push_data <= {2'b10, scan_code};
                r_state     <= S_IDLE;
              end
            end
            S_F0: begin
              r_state <= S_IDLE;
              if (scan_code == 8'hE0 || scan_code == 8'hF0) begin
                r_proto_err <= 1'b1;
              end else begin
                r_push      <= 1'b1;
                r_push_data <= {2'b01, scan_code};
              end
            end
            default: begin
              r_state <= S_IDLE;
              if (scan_code == 8'hE0 || scan_code == 8'hF0) begin
                r_proto_err <= 1'b1;
              end else begin
                r_push      <= 1'b1;
                r_push_data <= {2'b11, scan_code};
              end
            end
          endcase
        end
      end else if (r_state != S_IDLE) begin
        if (r_to_cnt == TO_LAST) begin
          r_state     <= S_IDLE;
          r_proto_err <= 1'b1;
          r_to_cnt    <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_wr_en = r_push & (~w_full | w_pop);

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (r_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Event storage; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_push_data;
    end
  end

  // Head is masked while empty so outputs read as zero after reset
  assign w_head      = w_empty ? 10'd0 : r_mem[r_rd_ptr[AW-1:0]];
  assign evt_code    = w_head[7:0];
  assign evt_release = w_head[8];
  assign evt_ext     = w_head[9];
  assign evt_valid   = ~w_empty;
  assign evt_count   = r_wr_ptr - r_rd_ptr;
  assign overflow    = r_overflow;
  assign proto_err   = r_proto_err;
  assign read        = r_read;

endmodule

// File: tb/tb_ps2_scan_controller.sv
// Directed and randomized bench for ps2_scan_controller with a prefix-list event model.
module tb_ps2_scan_controller;

  localparam int DEPTH = 4;
  localparam int TO    = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_ready;
  logic [7:0] scan_code;
  logic       read;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_count;
  logic       overflow;
  logic       proto_err;

  ps2_scan_controller #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .scan_ready(scan_ready), .scan_code(scan_code),
    .read(read), .evt_code(evt_code), .evt_ext(evt_ext), .evt_release(evt_release),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_count(evt_count),
    .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int read_pulses = 0;
  int last_read_cyc = 0;

  logic [9:0] exp_q[$];      // expected events {ext, release, code}
  logic [7:0] m_prefix[$];   // prefix bytes of the sequence in progress
  logic       exp_ovf = 1'b0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (read) read_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every pop the DUT performs is compared against the model head
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL pop_unexpected: observed %0h expected none", {evt_ext, evt_release, evt_code});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("pop_event", {22'd0, evt_ext, evt_release, evt_code}, {22'd0, e});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit pop_same);
    bit push, err, has_e0, has_f0;
    logic [9:0] ev;
    int n;
    push = 0; err = 0; ev = '0;
    if (b == 8'hE1) begin
      m_prefix.delete();
    end else if (b == 8'h00 || b == 8'hFF) begin
      err = 1; m_prefix.delete();
    end else if (b == 8'hE0) begin
      if (m_prefix.size() == 0) m_prefix.push_back(b);
      else if (!(m_prefix.size() == 1 && m_prefix[0] == 8'hE0)) begin
        err = 1; m_prefix.delete();
      end
    end else if (b == 8'hF0) begin
      if (m_prefix.size() == 0 || (m_prefix.size() == 1 && m_prefix[0] == 8'hE0))
        m_prefix.push_back(b);
      else begin
        err = 1; m_prefix.delete();
      end
    end else begin
      has_e0 = 0; has_f0 = 0;
      foreach (m_prefix[i]) begin
        if (m_prefix[i] == 8'hE0) has_e0 = 1;
        if (m_prefix[i] == 8'hF0) has_f0 = 1;
      end
      push = 1; ev = {has_e0, has_f0, b};
      m_prefix.delete();
    end

    @(posedge clk); #1;
    scan_code  = b;
    scan_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!read && n < 20);
    check("read_seen", {31'd0, read}, 32'd1);
    last_read_cyc = cyc;
    check("proto_err", {31'd0, proto_err}, {31'd0, err});
    if (pop_same) evt_ready = 1'b1;
    if (push) begin
      if (exp_q.size() >= DEPTH && !pop_same) exp_ovf = 1'b1;
      else exp_q.push_back(ev);
    end
    scan_ready = 1'b0;
    @(posedge clk); #1;
    check("read_one_cycle", {31'd0, read}, 32'd0);
    if (pop_same) evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    evt_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || evt_valid) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    evt_ready = 1'b0;
    check("drain_model_empty", exp_q.size(), 0);
    check("drain_count", {29'd0, evt_count}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read",     {31'd0, read},        32'd0);
    check("rst_valid",    {31'd0, evt_valid},   32'd0);
    check("rst_count",    {29'd0, evt_count},   32'd0);
    check("rst_overflow", {31'd0, overflow},    32'd0);
    check("rst_err",      {31'd0, proto_err},   32'd0);
    check("rst_evt",      {22'd0, evt_ext, evt_release, evt_code}, 32'd0);
    exp_q.delete();
    m_prefix.delete();
    exp_ovf = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int p0, n, r;
    logic [7:0] b;
    logic [7:0] codes [5];
    codes[0] = 8'h11; codes[1] = 8'h22; codes[2] = 8'h33; codes[3] = 8'h44; codes[4] = 8'h55;
    reset = 1'b1; scan_ready = 1'b0; scan_code = 8'h00; evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Single make code consumed immediately
    evt_ready = 1'b1;
    p0 = read_pulses;
    send_byte(8'h1C, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_read_pulses", read_pulses - p0, 1);
    check("t1_count", {29'd0, evt_count}, 32'd0);
    evt_ready = 1'b0;

    // Break and extended break queued, then popped in order
    send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
    check("t2_count", {29'd0, evt_count}, 32'd2);
    drain();

    // Dangling E0 times out; decoder recovers to plain codes
    send_byte(8'hE0, 1'b0);
    n = 0;
    while (!proto_err && n < 200) begin
      @(posedge clk); #1; n++;
    end
    m_prefix.delete();
    check("t3_timeout_seen", {31'd0, proto_err}, 32'd1);
    check("t3_timeout_cycle", cyc - last_read_cyc, TO);
    send_byte(8'h1C, 1'b0);
    drain();

    // Overflow with five pushes into a four-deep queue
    for (int i = 0; i < 5; i++) send_byte(codes[i], 1'b0);
    check("t4_count", {29'd0, evt_count}, 32'd4);
    check("t4_overflow", {31'd0, overflow}, {31'd0, exp_ovf});

    // Push into full queue with simultaneous pop: no drop
    send_byte(8'h66, 1'b1);
    check("t5_count", {29'd0, evt_count}, 32'd4);
    check("t5_model_size", exp_q.size(), 4);
    drain();
    check("t5_overflow_sticky", {31'd0, overflow}, {31'd0, exp_ovf});

    // Reset mid-sequence discards the pending release prefix
    send_byte(8'hF0, 1'b0);
    do_reset();
    send_byte(8'h1C, 1'b0);
    check("t6_count", {29'd0, evt_count}, 32'd1);
    drain();

    // Randomized byte stream with a consumer that is always ready
    evt_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      b = 8'hE0;
      else if (r < 35) b = 8'hF0;
      else if (r < 40) b = 8'hE1;
      else if (r < 42) b = 8'h00;
      else if (r < 44) b = 8'hFF;
      else             b = 8'($urandom_range(1, 8'h7F));
      send_byte(b, 1'b0);
    end
    send_byte(8'h1C, 1'b0);
    drain();
    check("rand_overflow", {31'd0, overflow}, {31'd0, exp_ovf});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
